// File: rtl/pss_pkg.sv
// Shared PSS definitions: sequence length, cyclic shift per N_id_2, the
// m-sequence start state and the transmit-side FSM state type. The same
// package feeds the receive-side correlator tap generation, so the LFSR
// recurrence lives here as a function both sides can call.
package pss_pkg;

  localparam int         PSS_LEN       = 127;
  localparam int         PSS_SHIFT     = 43;
  // Bit k holds x(i+k): bit 6 = x6 ... bit 0 = x0.
  localparam logic [6:0] PSS_LFSR_INIT = 7'b1110110;

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    EMIT
  } pss_gen_state_t;

  // One step of x(i+7) = x(i+4) XOR x(i). The window slides down by one
  // and the newly generated element enters at the top.
  function automatic logic [6:0] pssLfsrStep(input logic [6:0] state);
    return {state[4] ^ state[0], state[6:1]};
  endfunction

endpackage

// File: rtl/pss_lfsr.sv
// 7-bit Fibonacci register producing the PSS m-sequence.
// Ports:
//   clk_i, reset_i  clock and asynchronous active-high reset (reset = init)
//   i_load          reload the start state (wins over i_stepEn)
//   i_stepEn        advance the sequence by one element
//   o_bit           current element x(i)
//   o_nextBit       following element x(i+1), available without stepping
module pss_lfsr
  import pss_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic i_load,
  input  logic i_stepEn,
  output logic o_bit,
  output logic o_nextBit
);

  logic [6:0] r_state;

  // Sequence window: reload on a new request, otherwise step when asked.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= PSS_LFSR_INIT;
    end else if (i_load) begin
      r_state <= PSS_LFSR_INIT;
    end else if (i_stepEn) begin
      r_state <= pssLfsrStep(r_state);
    end
  end

  assign o_bit     = r_state[0];
  assign o_nextBit = r_state[1];

endmodule

// File: rtl/pss_generator.sv
// Transmit-side NR PSS source. A start request with N_id_2 in 0..2 produces
// the 127-sample BPSK PSS as {im, re} samples on an AXI-stream master.
// Ports:
//   clk_i, reset_i       clock and asynchronous active-high reset
//   start_i, N_id_2_i    one-cycle request and the cell-ID part sampled with it
//   busy_o               high from accepted start until the last handshake
//   m_axis_out_tdata     {im, re}; re = +/-AMP, im = 0
//   m_axis_out_tvalid    sample valid
//   m_axis_out_tready    downstream ready
//   m_axis_out_tlast     high on the final sample (n = 126)
module pss_generator
  import pss_pkg::*;
#(
  parameter int OUT_DW  = 32,
  parameter int AMP     = 8191,
  parameter int PSS_LEN = 127
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [1:0]        N_id_2_i,
  output logic              busy_o,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast
);

  localparam int               HALF      = OUT_DW / 2;
  localparam logic [HALF-1:0]  POS_AMP   = HALF'(AMP);
  localparam logic [HALF-1:0]  NEG_AMP   = -POS_AMP;
  localparam logic [6:0]       LAST_N    = 7'(PSS_LEN - 1);
  localparam logic [6:0]       PRELAST_N = 7'(PSS_LEN - 2);

  pss_gen_state_t    r_state;
  logic [6:0]        r_seekCnt;
  logic [6:0]        r_n;
  logic [OUT_DW-1:0] r_tdata;
  logic              r_tvalid;
  logic              r_tlast;
  logic              r_busy;

  logic w_accept;
  logic w_handshake;
  logic w_lfsrStep;
  logic w_bit;
  logic w_nextBit;

  // BPSK mapping: x=0 -> +AMP, x=1 -> -AMP; im is zero, so the upper half
  // is all zeros and the HALF-bit re field carries its own sign.
  function automatic logic [OUT_DW-1:0] bpskSample(input logic x);
    return {{HALF{1'b0}}, (x ? NEG_AMP : POS_AMP)};
  endfunction

  assign w_accept    = (r_state == IDLE) && start_i && (N_id_2_i != 2'd3);
  assign w_handshake = r_tvalid && m_axis_out_tready;

  // The LFSR walks forward while seeking the cyclic shift, then once per
  // accepted sample except after the last one.
  assign w_lfsrStep = ((r_state == SEEK) && (r_seekCnt != 7'd0)) ||
                      ((r_state == EMIT) && w_handshake && (r_n != LAST_N));

  pss_lfsr u_lfsr (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .i_load    (w_accept),
    .i_stepEn  (w_lfsrStep),
    .o_bit     (w_bit),
    .o_nextBit (w_nextBit)
  );

  // Main FSM with registered stream outputs. During EMIT the next sample is
  // taken from x(i+1) so a new beat can follow every accepted one.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_seekCnt <= 7'd0;
      r_n       <= 7'd0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_seekCnt <= 7'(PSS_SHIFT * int'(N_id_2_i));
            r_n       <= 7'd0;
            r_busy    <= 1'b1;
            r_state   <= SEEK;
          end
        end
        SEEK: begin
          if (r_seekCnt != 7'd0) begin
            r_seekCnt <= r_seekCnt - 7'd1;
          end else begin
            r_tdata  <= bpskSample(w_bit);
            r_tvalid <= 1'b1;
            r_tlast  <= (LAST_N == 7'd0);
            r_n      <= 7'd0;
            r_state  <= EMIT;
          end
        end
        EMIT: begin
          if (w_handshake) begin
            if (r_n == LAST_N) begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_busy   <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_n     <= r_n + 7'd1;
              r_tdata <= bpskSample(w_nextBit);
              r_tlast <= (r_n == PRELAST_N);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o            = r_busy;
  assign m_axis_out_tdata  = r_tdata;
  assign m_axis_out_tvalid = r_tvalid;
  assign m_axis_out_tlast  = r_tlast;

endmodule

// File: tb/tb_pss_generator.sv
module tb_pss_generator;

  localparam int AMP = 8191;
  localparam int LEN = 127;

  logic        clk_i;
  logic        reset_i;
  logic        start_i;
  logic [1:0]  N_id_2_i;
  logic        busy_o;
  logic [31:0] m_axis_out_tdata;
  logic        m_axis_out_tvalid;
  logic        m_axis_out_tready;
  logic        m_axis_out_tlast;

  pss_generator #(
    .OUT_DW  (32),
    .AMP     (AMP),
    .PSS_LEN (127)
  ) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .start_i           (start_i),
    .N_id_2_i          (N_id_2_i),
    .busy_o            (busy_o),
    .m_axis_out_tdata  (m_axis_out_tdata),
    .m_axis_out_tvalid (m_axis_out_tvalid),
    .m_axis_out_tready (m_axis_out_tready),
    .m_axis_out_tlast  (m_axis_out_tlast)
  );

  // Free-running clock, period 10.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checkCount = 0;
  int passCount  = 0;

  // Reference m-sequence built straight from the recurrence.
  bit baseX[LEN];

  // Stream bookkeeping: the driver counts accepted starts and aborts, the
  // monitor counts completed streams.
  int expN         = 0;
  int startsIssued = 0;
  int abortCount   = 0;
  int streamsDone  = 0;
  int beatIdx      = 0;
  bit randReady    = 0;
  logic [15:0] capRe[LEN];
  logic [15:0] stream0[LEN];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected sample: d(n) uses x((n + 43*N_id_2) mod 127); im = 0.
  function automatic logic [31:0] modelSample(input int nid, input int n);
    logic [15:0] re;
    re = baseX[(n + 43 * nid) % LEN] ? 16'(-AMP) : 16'(AMP);
    return {16'h0000, re};
  endfunction

  // Ready generator: always ready, or a fair coin per cycle.
  initial begin
    m_axis_out_tready = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      m_axis_out_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: every negedge compares whatever the DUT presents against the
  // model, checks AXI stability under backpressure and busy_o falling after
  // the final handshake.
  initial begin
    bit          prevStall;
    bit          doneFlag;
    logic [31:0] prevData;
    logic        prevLast;
    bit          active;
    prevStall = 0;
    doneFlag  = 0;
    prevData  = '0;
    prevLast  = 0;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        beatIdx   = 0;
        prevStall = 0;
        doneFlag  = 0;
      end else begin
        active = (startsIssued > streamsDone + abortCount);
        if (doneFlag) begin
          checkOutput("busyAfterLast", 32'(busy_o), 32'd0);
          doneFlag = 0;
        end
        if (prevStall) begin
          checkOutput("stallValid", 32'(m_axis_out_tvalid), 32'd1);
          checkOutput("stallData", m_axis_out_tdata, prevData);
          checkOutput("stallLast", 32'(m_axis_out_tlast), 32'(prevLast));
        end
        if (m_axis_out_tvalid) begin
          checkOutput("validWhileActive", 32'(active), 32'd1);
          if (active) begin
            checkOutput("sample", m_axis_out_tdata, modelSample(expN, beatIdx));
            checkOutput("tlast", 32'(m_axis_out_tlast), 32'(beatIdx == LEN - 1));
            checkOutput("busyDuringStream", 32'(busy_o), 32'd1);
          end
          if (m_axis_out_tready) begin
            if (beatIdx < LEN) capRe[beatIdx] = m_axis_out_tdata[15:0];
            beatIdx++;
            if (beatIdx == LEN) begin
              beatIdx = 0;
              streamsDone++;
              doneFlag = 1;
            end
          end
        end
        prevStall = m_axis_out_tvalid && !m_axis_out_tready;
        prevData  = m_axis_out_tdata;
        prevLast  = m_axis_out_tlast;
      end
    end
  end

  // Issue an accepted start; returns just after the accepting edge.
  task automatic applyStimulus(input int n);
    @(posedge clk_i);
    #1;
    expN = n;
    startsIssued++;
    start_i  = 1'b1;
    N_id_2_i = 2'(n);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Start pulse the DUT must ignore (invalid ID or while busy).
  task automatic pulseIgnored(input int n);
    @(posedge clk_i);
    #1;
    start_i  = 1'b1;
    N_id_2_i = 2'(n);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Edges from the accepting edge to the one raising tvalid.
  task automatic checkLatency(input int n, input int expEdges);
    int lat;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!m_axis_out_tvalid && lat < 400);
    checkOutput($sformatf("latencyN%0d", n), 32'(lat - 1), 32'(expEdges));
  endtask

  task automatic waitIdle(input int doneBefore);
    int c;
    c = 0;
    while (busy_o && c < 3000) begin
      @(negedge clk_i);
      c++;
    end
    checkOutput("idleTimeout", 32'(c < 3000), 32'd1);
    checkOutput("streamCount", 32'(streamsDone), 32'(doneBefore + 1));
  endtask

  task automatic waitBeat(input int target);
    int c;
    c = 0;
    while (beatIdx < target && c < 2000) begin
      @(negedge clk_i);
      c++;
    end
    checkOutput("beatTimeout", 32'(c < 2000), 32'd1);
  endtask

  initial begin
    int d;
    int sum;
    int n;
    int c;
    bit quiet;
    logic [15:0] first8[8];

    baseX[0] = 0; baseX[1] = 1; baseX[2] = 1; baseX[3] = 0;
    baseX[4] = 1; baseX[5] = 1; baseX[6] = 1;
    for (int i = 0; i + 7 < LEN; i++) baseX[i + 7] = baseX[i + 4] ^ baseX[i];

    first8[0] = 16'h1FFF; first8[1] = 16'hE001; first8[2] = 16'hE001; first8[3] = 16'h1FFF;
    first8[4] = 16'hE001; first8[5] = 16'hE001; first8[6] = 16'hE001; first8[7] = 16'hE001;

    reset_i  = 1'b1;
    start_i  = 1'b0;
    N_id_2_i = 2'd0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("resetValid", 32'(m_axis_out_tvalid), 32'd0);
    checkOutput("resetBusy", 32'(busy_o), 32'd0);
    checkOutput("resetData", m_axis_out_tdata, 32'd0);
    checkOutput("resetLast", 32'(m_axis_out_tlast), 32'd0);
    reset_i = 1'b0;

    // Test 1: N_id_2=0, always ready; pin the model with literal values.
    d = streamsDone;
    applyStimulus(0);
    checkLatency(0, 1);
    waitIdle(d);
    sum = 0;
    for (int i = 0; i < LEN; i++) begin
      sum += int'($signed(capRe[i]));
      stream0[i] = capRe[i];
    end
    for (int i = 0; i < 8; i++) checkOutput($sformatf("first8_%0d", i), 32'(capRe[i]), 32'(first8[i]));
    checkOutput("sumRe", 32'(sum), 32'(-8191));

    // Test 2: shifted sequences are rotations of the N_id_2=0 stream.
    for (int k = 1; k <= 2; k++) begin
      d = streamsDone;
      applyStimulus(k);
      checkLatency(k, (k == 1) ? 44 : 87);
      waitIdle(d);
      c = 0;
      for (int i = 0; i < LEN; i++) if (capRe[i] !== stream0[(i + 43 * k) % LEN]) c++;
      checkOutput($sformatf("rotationN%0d", k), 32'(c), 32'd0);
    end

    // Test 3: random backpressure, same sequence as test 1.
    randReady = 1;
    d = streamsDone;
    applyStimulus(0);
    waitIdle(d);
    c = 0;
    for (int i = 0; i < LEN; i++) if (capRe[i] !== stream0[i]) c++;
    checkOutput("backpressureSeq", 32'(c), 32'd0);
    randReady = 0;

    // Test 4: invalid ID ignored, then a start during EMIT ignored.
    pulseIgnored(3);
    quiet = 1;
    repeat (60) begin
      @(negedge clk_i);
      if (m_axis_out_tvalid || busy_o) quiet = 0;
    end
    checkOutput("nid3Ignored", 32'(quiet), 32'd1);
    d = streamsDone;
    applyStimulus(0);
    waitBeat(20);
    pulseIgnored(1);
    waitIdle(d);
    repeat (5) @(negedge clk_i);
    checkOutput("noExtraStream", 32'(busy_o), 32'd0);

    // Test 5: asynchronous reset mid-EMIT, then clean restart.
    randReady = 1;
    applyStimulus(0);
    waitBeat(51);
    @(posedge clk_i);
    #3;
    reset_i = 1'b1;
    abortCount++;
    #1;
    checkOutput("asyncResetValid", 32'(m_axis_out_tvalid), 32'd0);
    checkOutput("asyncResetBusy", 32'(busy_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    randReady = 0;
    d = streamsDone;
    applyStimulus(0);
    waitIdle(d);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("restart_%0d", i), 32'(capRe[i]), 32'(first8[i]));

    // Test 6: back-to-back start right after the tlast handshake.
    d = streamsDone;
    applyStimulus(1);
    waitBeat(LEN - 1);
    c = 0;
    while (!(m_axis_out_tvalid && m_axis_out_tready && m_axis_out_tlast) && c < 100) begin
      @(negedge clk_i);
      c++;
    end
    checkOutput("lastBeatTimeout", 32'(c < 100), 32'd1);
    applyStimulus(2);
    checkLatency(2, 87);
    waitIdle(d + 1);

    // A few fully random runs.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(0, 2);
      randReady = 1'($urandom_range(0, 1));
      d = streamsDone;
      applyStimulus(n);
      checkLatency(n, 1 + 43 * n);
      waitIdle(d);
    end
    randReady = 0;

    repeat (3) @(posedge clk_i);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
